// File: rtl/qspi_data_fifo.sv
// Synchronous word FIFO between dma_engine and the QSPI shift stage.
// Registered read port (1-cycle latency), occupancy level, and sticky overflow/underflow flags.
module qspi_data_fifo #(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 16,
   parameter int LEVEL_WIDTH   = 5,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic [LEVEL_WIDTH-1:0] level_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   input  logic                  clr_err_i
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wptr;
   logic [AW:0]           r_rptr;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic [AW:0] w_level;
   logic        w_full;
   logic        w_empty;
   logic        w_wr_acc;
   logic        w_rd_acc;
   logic        w_wr_rej;
   logic        w_rd_rej;

   // Wrap bit in the pointer MSB lets a plain subtraction give 0..DEPTH.
   assign w_level  = r_wptr - r_rptr;
   assign w_full   = (w_level == (AW+1)'(DEPTH));
   assign w_empty  = (w_level == '0);
   assign w_wr_acc = wr_en_i && !w_full;
   assign w_rd_acc = rd_en_i && !w_empty;
   assign w_wr_rej = wr_en_i && w_full;
   assign w_rd_rej = rd_en_i && w_empty;

   assign level_o        = LEVEL_WIDTH'(w_level);
   assign full_o         = w_full;
   assign empty_o        = w_empty;
   assign almost_full_o  = (w_level >= (AW+1)'(AFULL_THRESH));
   assign almost_empty_o = (w_level <= (AW+1)'(AEMPTY_THRESH));
   assign rd_data_o      = r_rd_data;
   assign rd_valid_o     = r_rd_valid;
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

   // Storage is deliberately left out of reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && w_wr_acc)
         r_mem[r_wptr[AW-1:0]] <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (flush_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_rd_valid <= 1'b0;
         if (clr_err_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end
      end else begin
         if (w_wr_acc)
            r_wptr <= r_wptr + (AW+1)'(1);
         if (w_rd_acc) begin
            r_rptr    <= r_rptr + (AW+1)'(1);
            r_rd_data <= r_mem[r_rptr[AW-1:0]];
         end
         r_rd_valid <= w_rd_acc;

         // A same-cycle error event beats the clear.
         if (w_wr_rej)
            r_overflow <= 1'b1;
         else if (clr_err_i)
            r_overflow <= 1'b0;

         if (w_rd_rej)
            r_underflow <= 1'b1;
         else if (clr_err_i)
            r_underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_qspi_data_fifo.sv
// Self-checking bench for qspi_data_fifo: hand-written vector table, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_qspi_data_fifo;

   localparam int DW = 32;
   localparam int D  = 16;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          rst, flush_i, wr_en_i, rd_en_i, clr_err_i;
   logic [DW-1:0] wr_data_i;
   logic [DW-1:0] rd_data_o;
   logic          rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
   logic          overflow_o, underflow_o;
   logic [LW-1:0] level_o;

   qspi_data_fifo #(
      .DATA_WIDTH(DW), .DEPTH(D), .LEVEL_WIDTH(LW), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
      .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .level_o(level_o),
      .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
      .almost_empty_o(almost_empty_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
      .clr_err_i(clr_err_i)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: FIFO contents as a queue plus the observable registers.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_data;
   logic          m_valid, m_ovf, m_unf;

   typedef struct {
      logic          rst, flush, wr, rd, clr;
      logic [DW-1:0] wd;
      int            lvl;
      logic          valid;
      logic [DW-1:0] data;
      logic          ovf, unf;
   } vec_t;

   vec_t tv[16];

   function automatic vec_t mk(logic r, logic f, logic w, logic [DW-1:0] wd, logic rd, logic c,
                               int lvl, logic v, logic [DW-1:0] d, logic ov, logic un);
      vec_t t;
      t.rst = r; t.flush = f; t.wr = w; t.wd = wd; t.rd = rd; t.clr = c;
      t.lvl = lvl; t.valid = v; t.data = d; t.ovf = ov; t.unf = un;
      return t;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_outputs(input string tag, input int lvl, input logic v, input logic [DW-1:0] d,
                              input logic ov, input logic un);
      chk({tag, ".level"},  DW'(level_o), DW'(lvl));
      chk({tag, ".full"},   DW'(full_o),  DW'(lvl == D));
      chk({tag, ".empty"},  DW'(empty_o), DW'(lvl == 0));
      chk({tag, ".afull"},  DW'(almost_full_o),  DW'(lvl >= 12));
      chk({tag, ".aempty"}, DW'(almost_empty_o), DW'(lvl <= 4));
      chk({tag, ".valid"},  DW'(rd_valid_o), DW'(v));
      chk({tag, ".data"},   rd_data_o, d);
      chk({tag, ".ovf"},    DW'(overflow_o),  DW'(ov));
      chk({tag, ".unf"},    DW'(underflow_o), DW'(un));
   endtask

   task automatic chk_model(input string tag);
      chk_outputs(tag, mq.size(), m_valid, m_data, m_ovf, m_unf);
   endtask

   // Drive one cycle, advance the model from its pre-edge state, sample 1 ns after the edge.
   task automatic cycle(input logic r, input logic f, input logic w, input logic [DW-1:0] wd,
                        input logic rd, input logic c);
      logic was_full, was_empty;
      rst = r; flush_i = f; wr_en_i = w; wr_data_i = wd; rd_en_i = rd; clr_err_i = c;
      if (r) begin
         mq.delete(); m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (f) begin
         mq.delete(); m_valid = 1'b0;
         if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
      end else begin
         was_full  = (mq.size() == D);
         was_empty = (mq.size() == 0);
         m_valid   = rd && !was_empty;
         if (rd && !was_empty) m_data = mq.pop_front();
         if (w && !was_full) mq.push_back(wd);
         if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
         if (rd && was_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(0, 0, 0, '0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush_i = 0; wr_en_i = 0; rd_en_i = 0; clr_err_i = 0; wr_data_i = '0;

      tv[0]  = mk(0,0,1,32'h01020304,0,0, 1,0,32'h0,        0,0);
      tv[1]  = mk(0,0,1,32'h11121314,0,0, 2,0,32'h0,        0,0);
      tv[2]  = mk(0,0,1,32'h21222324,0,0, 3,0,32'h0,        0,0);
      tv[3]  = mk(0,0,1,32'h31323334,0,0, 4,0,32'h0,        0,0);
      tv[4]  = mk(0,0,0,32'h0,       1,0, 3,1,32'h01020304, 0,0);
      tv[5]  = mk(0,0,0,32'h0,       1,0, 2,1,32'h11121314, 0,0);
      tv[6]  = mk(0,0,0,32'h0,       1,0, 1,1,32'h21222324, 0,0);
      tv[7]  = mk(0,0,0,32'h0,       1,0, 0,1,32'h31323334, 0,0);
      tv[8]  = mk(0,0,0,32'h0,       0,0, 0,0,32'h31323334, 0,0);
      tv[9]  = mk(0,0,0,32'h0,       1,0, 0,0,32'h31323334, 0,1);
      tv[10] = mk(0,0,0,32'h0,       0,1, 0,0,32'h31323334, 0,0);
      tv[11] = mk(0,0,1,32'hAAAA0001,1,0, 1,0,32'h31323334, 0,1);
      tv[12] = mk(0,0,0,32'h0,       1,1, 0,1,32'hAAAA0001, 0,0);
      tv[13] = mk(0,0,1,32'hBBBB0002,0,0, 1,0,32'hAAAA0001, 0,0);
      tv[14] = mk(0,1,1,32'hCCCC0003,1,0, 0,0,32'hAAAA0001, 0,0);
      tv[15] = mk(1,0,0,32'h0,       0,0, 0,0,32'h0,        0,0);

      cycle(1, 0, 0, '0, 0, 0);
      cycle(1, 0, 0, '0, 0, 0);
      chk_outputs("reset", 0, 0, '0, 0, 0);

      foreach (tv[i]) begin
         cycle(tv[i].rst, tv[i].flush, tv[i].wr, tv[i].wd, tv[i].rd, tv[i].clr);
         chk_outputs($sformatf("vec%0d", i), tv[i].lvl, tv[i].valid, tv[i].data, tv[i].ovf, tv[i].unf);
      end

      // Fill to full, overflow, drain, clear.
      for (int i = 0; i < D; i++) begin
         cycle(0, 0, 1, 32'h5000_0000 + i, 0, 0);
         chk_model($sformatf("fill%0d", i));
      end
      cycle(0, 0, 1, 32'hDEAD_BEEF, 0, 0);
      chk_model("overflow");
      for (int i = 0; i < D; i++) begin
         cycle(0, 0, 0, '0, 1, 0);
         chk_model($sformatf("drain%0d", i));
      end
      cycle(0, 0, 0, '0, 0, 1);
      chk_model("clr_ovf");

      // Simultaneous rd+wr at full and at mid level.
      for (int i = 0; i < D; i++) cycle(0, 0, 1, 32'h6000_0000 + i, 0, 0);
      cycle(0, 0, 1, 32'h7777_7777, 1, 0);
      chk_model("rdwr_full");
      while (mq.size() > 8) cycle(0, 0, 0, '0, 1, 0);
      cycle(0, 0, 1, 32'h8888_8888, 1, 1);
      chk_model("rdwr_mid");
      while (mq.size() > 0) begin
         cycle(0, 0, 0, '0, 1, 0);
         chk_model("drain_b");
      end

      // Interleaved traffic at low level to exercise pointer wrap.
      cycle(0, 0, 1, 32'h9000_0000, 0, 0);
      cycle(0, 0, 1, 32'h9000_0001, 0, 0);
      for (int i = 2; i < 42; i++) begin
         cycle(0, 0, 1, 32'h9000_0000 + i, (i % 3) != 0, 0);
         if (mq.size() >= 3) cycle(0, 0, 0, '0, 1, 0);
         chk_model($sformatf("wrap%0d", i));
      end

      // Flush with same-cycle write, then reset mid-stream.
      while (mq.size() < 5) cycle(0, 0, 1, $urandom, 0, 0);
      cycle(0, 1, 1, 32'hF1F1_F1F1, 0, 0);
      chk_model("flush_wr");
      while (mq.size() < 5) cycle(0, 0, 1, $urandom, 0, 0);
      cycle(0, 0, 0, '0, 1, 0);
      cycle(1, 0, 1, 32'hF2F2_F2F2, 1, 0);
      chk_model("rst_mid");
      cycle(0, 0, 0, '0, 1, 0);
      chk_model("rd_after_rst");

      // Randomized traffic with phases biased toward filling and draining.
      for (int blk = 0; blk < 10; blk++) begin
         int wp;
         wp = (blk % 2) ? 75 : 30;
         for (int c = 0; c < 200; c++) begin
            cycle($urandom_range(0, 499) == 0,
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < wp,
                  $urandom,
                  $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 4);
            chk_model($sformatf("rnd%0d_%0d", blk, c));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
